// File: rtl/backing_mem_if.sv
// Request/response bundle between a memory client and backing_mem_model.
// The client drives requests and backpressure; the memory drives credits and responses.
interface backing_mem_if #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 1
);
  logic              en;
  logic              req_rden;
  logic              req_wren;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_wdata;
  logic [ID_W-1:0]   req_id;
  logic              rd_ready;
  logic              resp_valid;
  logic [LINE_W-1:0] resp_data;
  logic [ID_W-1:0]   resp_id;
  logic              resp_ready;
  logic              err_drop;

  modport master (
    output en, req_rden, req_wren, req_addr,
    output req_wdata, req_id, resp_ready,
    input  rd_ready, resp_valid, resp_data,
    input  resp_id, err_drop
  );

  modport slave (
    input  en, req_rden, req_wren, req_addr,
    input  req_wdata, req_id, resp_ready,
    output rd_ready, resp_valid, resp_data,
    output resp_id, err_drop
  );
endinterface

// File: rtl/backing_mem_model.sv
// Downstream cacheline memory model: stores writes and returns real data
// for reads through a credit-limited, enable-gated pipe and a response FIFO.
module backing_mem_model #(
  parameter int LINE_W      = 128,
  parameter int ADDR_W      = 32,
  parameter int OFFSET_BITS = 4,
  parameter int INDEX_BITS  = 8,
  parameter int LATENCY     = 5,
  parameter int ID_W        = 1,
  parameter int RESP_DEPTH  = 4
) (
  input logic         clk,
  input logic         reset,
  backing_mem_if.slave bus
);
  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK =
    ADDR_W'((64'd1 << OFFSET_BITS) - 64'd1);

  logic [LINE_W-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0]      wb_q, wb_d;
  logic [LATENCY-1:0]    pv_q, pv_d;
  logic [LINE_W-1:0]     pd_q [LATENCY];
  logic [ID_W-1:0]       pi_q [LATENCY];
  logic [LINE_W-1:0]     fd_q [RESP_DEPTH];
  logic [ID_W-1:0]       fi_q [RESP_DEPTH];
  logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]         cnt_q, cnt_d, out_q, out_d;
  logic                  err_q, err_d;

  logic [INDEX_BITS-1:0] idx;
  logic [ADDR_W-1:0]     a_clr;
  logic [31:0]           pat;
  logic [LINE_W-1:0]     rd_data;
  logic                  rd_ready;
  logic                  wr_acc, rd_acc, drop, push, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_ready = out_q < CW'(RESP_DEPTH);

  always_comb begin
    idx    = bus.req_addr[OFFSET_BITS +: INDEX_BITS];
    a_clr  = bus.req_addr & ~OFF_MASK;
    pat    = 32'(a_clr);
    wr_acc = bus.en & bus.req_wren;
    rd_acc = bus.en & bus.req_rden & rd_ready;
    drop   = bus.en & bus.req_rden & ~rd_ready;
    push   = bus.en & pv_q[LATENCY-1];
    pop    = (cnt_q != '0) & bus.resp_ready;
    // A same-cycle write to the read index wins and is forwarded
    if (wr_acc)
      rd_data = bus.req_wdata;
    else if (wb_q[idx])
      rd_data = mem_q[idx];
    else
      rd_data = {(LINE_W/32){pat}};
  end

  always_comb begin
    pv_d = pv_q;
    if (bus.en) begin
      pv_d[0] = rd_acc;
      for (int i = 1; i < LATENCY; i++)
        pv_d[i] = pv_q[i-1];
    end
    wb_d = wb_q;
    if (wr_acc)
      wb_d[idx] = 1'b1;
    wp_d  = push ? nxt(wp_q) : wp_q;
    rp_d  = pop ? nxt(rp_q) : rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    // Retiring into the FIFO keeps a credit; only pops return one
    out_d = out_q + CW'(rd_acc) - CW'(pop);
    err_d = err_q | drop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q  <= '0;
      wb_q  <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      pv_q  <= pv_d;
      wb_q  <= wb_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem_q[idx] <= bus.req_wdata;
    if (bus.en) begin
      pd_q[0] <= rd_data;
      pi_q[0] <= bus.req_id;
      for (int i = 1; i < LATENCY; i++) begin
        pd_q[i] <= pd_q[i-1];
        pi_q[i] <= pi_q[i-1];
      end
    end
    if (push) begin
      fd_q[wp_q] <= pd_q[LATENCY-1];
      fi_q[wp_q] <= pi_q[LATENCY-1];
    end
  end

  assign bus.rd_ready   = rd_ready;
  assign bus.resp_valid = cnt_q != '0;
  assign bus.resp_data  = (cnt_q != '0) ? fd_q[rp_q] : '0;
  assign bus.resp_id    = (cnt_q != '0) ? fi_q[rp_q] : '0;
  assign bus.err_drop   = err_q;
endmodule
